smiley_collision_detector: RTL

//  Pixel-stream collision stage directly downstream of the smiley drawing block.
//  - Compares draw_smiley with the borders, flipper and bumper draw strobes, pixel by pixel.
//  - Emits one-cycle collision pulses consumed by the smiley controller
//    (collisionSmileyBorders / collisionSmileyFlipper) and by the score logic.
//  - Enforces at most one pulse per type per frame, plus a frame-based holdoff so the

---
 rtl/collision_pkg.sv | 18 +
 rtl/smiley_collision_detector_if.sv | 38 +++
 rtl/collision_holdoff.sv | 52 +++++
 rtl/smiley_collision_detector.sv | 68 ++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and helpers for the smiley collision stage.
package collision_pkg;

   localparam int COORD_W       = 11;
   localparam int NUM_HIT_TYPES = 3;

   typedef enum logic [1:0] {
      HIT_BORDER  = 2'd0,
      HIT_FLIPPER = 2'd1,
      HIT_BUMPER  = 2'd2
   } hit_type_t;

   // Counter width able to hold the holdoff load value (at least one bit).
   function automatic int holdoff_w(input int frames);
      return (frames < 2) ? 1 : $clog2(frames + 1);
   endfunction

endpackage

// File: rtl/smiley_collision_detector_if.sv
// Pixel-stream strobes in, collision pulses and hit information out.
// master = pixel/draw source, slave = collision detector.
interface smiley_collision_detector_if
   import collision_pkg::*;
#(
   parameter int NUM_BUMPERS = 4
) ();
   localparam int IDX_W = (NUM_BUMPERS > 1) ? $clog2(NUM_BUMPERS) : 1;

   logic                      startOfFrame;
   logic signed [COORD_W-1:0] PixelX;
   logic signed [COORD_W-1:0] PixelY;
   logic                      draw_smiley;
   logic                      draw_borders;
   logic                      draw_flipper;
   logic [NUM_BUMPERS-1:0]    draw_bumpers;

   logic                      collisionSmileyBorders;
   logic                      collisionSmileyFlipper;
   logic                      collisionSmileyBumper;
   logic [IDX_W-1:0]          bumperHitIdx;
   logic signed [COORD_W-1:0] hitX;
   logic signed [COORD_W-1:0] hitY;

   modport master (
      output startOfFrame, PixelX, PixelY, draw_smiley, draw_borders,
             draw_flipper, draw_bumpers,
      input  collisionSmileyBorders, collisionSmileyFlipper,
             collisionSmileyBumper, bumperHitIdx, hitX, hitY
   );

   modport slave (
      input  startOfFrame, PixelX, PixelY, draw_smiley, draw_borders,
             draw_flipper, draw_bumpers,
      output collisionSmileyBorders, collisionSmileyFlipper,
             collisionSmileyBumper, bumperHitIdx, hitX, hitY
   );
endinterface

// File: rtl/collision_holdoff.sv
// Per-hit-type gate: one pulse per frame, then HOLDOFF_FRAMES silent frames.
// The holdoff counter is not decremented on the frame boundary that ends the
// pulse frame itself, so a pulse in frame k keeps the type quiet through
// frame k+HOLDOFF_FRAMES and re-arms it in frame k+HOLDOFF_FRAMES+1.
module collision_holdoff
   import collision_pkg::*;
#(
   parameter int HOLDOFF_FRAMES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic startOfFrame,
   input  logic overlap,
   output logic eligible
);
   localparam int           W         = holdoff_w(HOLDOFF_FRAMES);
   localparam logic [W-1:0] HOLD_LOAD = W'(HOLDOFF_FRAMES);

   logic         fired_q, fired_d, fired_now;
   logic [W-1:0] holdoff_q, holdoff_d, holdoff_now;

   // State as seen by the current pixel: a startOfFrame pixel already belongs to the new frame.
   always_comb begin
      fired_now   = fired_q & ~startOfFrame;
      holdoff_now = holdoff_q;
      if (startOfFrame && !fired_q && (holdoff_q != '0))
         holdoff_now = holdoff_q - 1'b1;
   end

   assign eligible = overlap & ~fired_now & (holdoff_now == '0);

   // Next state: a new hit reloads the holdoff, otherwise carry the frame-adjusted values.
   always_comb begin
      fired_d   = fired_now;
      holdoff_d = holdoff_now;
      if (eligible) begin
         fired_d   = 1'b1;
         holdoff_d = HOLD_LOAD;
      end
   end

   // Fired flag and holdoff counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fired_q   <= 1'b0;
         holdoff_q <= '0;
      end else begin
         fired_q   <= fired_d;
         holdoff_q <= holdoff_d;
      end
   end
endmodule

// File: rtl/smiley_collision_detector.sv
// Pixel-level collision detection between the smiley and borders/flipper/bumpers.
// Pulses appear one clock after the overlapping pixel; hit pixel and bumper index are held.
module smiley_collision_detector
   import collision_pkg::*;
#(
   parameter int NUM_BUMPERS    = 4,
   parameter int HOLDOFF_FRAMES = 2
) (
   input logic                        clk,
   input logic                        reset,
   smiley_collision_detector_if.slave bus
);
   localparam int IDX_W = (NUM_BUMPERS > 1) ? $clog2(NUM_BUMPERS) : 1;

   logic [NUM_HIT_TYPES-1:0]  overlap;
   logic [NUM_HIT_TYPES-1:0]  eligible;
   logic [NUM_HIT_TYPES-1:0]  pulse_q;
   logic [IDX_W-1:0]          idx_d, idx_q;
   logic signed [COORD_W-1:0] hit_x_q, hit_y_q;

   assign overlap[HIT_BORDER]  = bus.draw_smiley & bus.draw_borders;
   assign overlap[HIT_FLIPPER] = bus.draw_smiley & bus.draw_flipper;
   assign overlap[HIT_BUMPER]  = bus.draw_smiley & (|bus.draw_bumpers);

   for (genvar t = 0; t < NUM_HIT_TYPES; t++) begin : g_holdoff
      collision_holdoff #(
         .HOLDOFF_FRAMES (HOLDOFF_FRAMES)
      ) u_holdoff (
         .clk          (clk),
         .reset        (reset),
         .startOfFrame (bus.startOfFrame),
         .overlap      (overlap[t]),
         .eligible     (eligible[t])
      );
   end

   // Lowest-indexed opaque bumper wins.
   always_comb begin
      idx_d = '0;
      for (int i = NUM_BUMPERS - 1; i >= 0; i--)
         if (bus.draw_bumpers[i]) idx_d = IDX_W'(i);
   end

   // Pulse registers plus hit-pixel and bumper-index latches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pulse_q <= '0;
         idx_q   <= '0;
         hit_x_q <= '0;
         hit_y_q <= '0;
      end else begin
         pulse_q <= eligible;
         if (|eligible) begin
            hit_x_q <= bus.PixelX;
            hit_y_q <= bus.PixelY;
         end
         if (eligible[HIT_BUMPER])
            idx_q <= idx_d;
      end
   end

   assign bus.collisionSmileyBorders = pulse_q[HIT_BORDER];
   assign bus.collisionSmileyFlipper = pulse_q[HIT_FLIPPER];
   assign bus.collisionSmileyBumper  = pulse_q[HIT_BUMPER];
   assign bus.bumperHitIdx           = idx_q;
   assign bus.hitX                   = hit_x_q;
   assign bus.hitY                   = hit_y_q;
endmodule
